pad_step_sequencer: RTL and testbench



---
 rtl/pad_step_sequencer_pkg.sv | 13 +
 rtl/pad_step_sequencer_pattern_bit_array.sv | 30 +++
 rtl/pad_step_sequencer.sv | 116 +++++++++++
 tb/tb_pad_step_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pad_step_sequencer_pkg.sv
// Shared types and defaults for the pad step sequencer.
package pad_step_sequencer_pkg;

    localparam int unsigned DEF_STEPS = 8;
    localparam int unsigned DEF_ROWS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CLEAR = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pad_step_sequencer_pattern_bit_array.sv
// STEPS x ROWS grid of clock-enabled D flops holding the pad pattern.
module pad_step_sequencer_pattern_bit_array
    import pad_step_sequencer_pkg::*;
#(
    parameter int unsigned STEPS = DEF_STEPS,
    parameter int unsigned ROWS  = DEF_ROWS
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [STEPS-1:0][ROWS-1:0] en,
    input  logic [STEPS-1:0][ROWS-1:0] nd,
    output logic [STEPS-1:0][ROWS-1:0] bits
);

    // Each bit loads nd only when its own enable is set.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            bits <= '0;
        end else begin
            for (int s = 0; s < int'(STEPS); s++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    if (en[s][r]) begin
                        bits[s][r] <= nd[s][r];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pad_step_sequencer.sv
// Launchpad step sequencer controller: pad toggles, bulk clear and tempo-driven step playback.
module pad_step_sequencer
    import pad_step_sequencer_pkg::*;
#(
    parameter int unsigned STEPS = DEF_STEPS,
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned SW    = 3,
    parameter int unsigned RW    = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Tick,
    input  logic            Run,
    input  logic            PadValid,
    input  logic [SW-1:0]   PadStep,
    input  logic [RW-1:0]   PadRow,
    input  logic            Clear,
    output logic [SW-1:0]   Step,
    output logic [ROWS-1:0] Column,
    output logic            StepStrobe,
    output logic            Busy
);

    seq_state_t state_q, state_n;
    logic [SW-1:0]   step_n;
    logic [SW-1:0]   clr_q, clr_n;
    logic [ROWS-1:0] col_n;
    logic            strobe_n;
    logic            busy_n;

    logic [STEPS-1:0][ROWS-1:0] bit_en;
    logic [STEPS-1:0][ROWS-1:0] bit_nd;
    logic [STEPS-1:0][ROWS-1:0] bit_q;

    pad_step_sequencer_pattern_bit_array #(
        .STEPS(STEPS),
        .ROWS (ROWS)
    ) u_array (
        .CLK (CLK),
        .RST (RST),
        .en  (bit_en),
        .nd  (bit_nd),
        .bits(bit_q)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            Step       <= '0;
            clr_q      <= '0;
            Column     <= '0;
            StepStrobe <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state_q    <= state_n;
            Step       <= step_n;
            clr_q      <= clr_n;
            Column     <= col_n;
            StepStrobe <= strobe_n;
            Busy       <= busy_n;
        end
    end

    // Column is reloaded every non-clear cycle from the pre-edge array, so a
    // toggle on the shown step appears exactly one cycle after it lands.
    always_comb begin
        state_n  = state_q;
        step_n   = Step;
        clr_n    = clr_q;
        col_n    = Column;
        strobe_n = 1'b0;
        busy_n   = 1'b0;
        bit_en   = '0;
        bit_nd   = ~bit_q;

        case (state_q)
            IDLE, PLAY: begin
                if (Clear) begin
                    state_n = CLEAR;
                    clr_n   = '0;
                    busy_n  = 1'b1;
                end else begin
                    if (state_q == IDLE) begin
                        if (Run) state_n = PLAY;
                    end else begin
                        if (Tick) begin
                            step_n   = Step + SW'(1);
                            strobe_n = 1'b1;
                        end
                        if (!Run) state_n = IDLE;
                    end
                    if (PadValid && (32'(PadRow) < ROWS)) begin
                        bit_en[PadStep][PadRow] = 1'b1;
                    end
                    col_n = bit_q[step_n];
                end
            end

            CLEAR: begin
                bit_en[clr_q] = '1;
                bit_nd        = '0;
                busy_n        = 1'b1;
                clr_n         = clr_q + SW'(1);
                if (clr_q == SW'(STEPS - 1)) begin
                    busy_n  = 1'b0;
                    step_n  = '0;
                    col_n   = '0;
                    state_n = Run ? PLAY : IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pad_step_sequencer.sv
// Directed self-checking bench for pad_step_sequencer.
module tb_pad_step_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, run, pad_valid, clear;
    logic [2:0] pad_step, pad_row;
    logic [2:0] step;
    logic [7:0] column;
    logic       step_strobe, busy;

    int checks = 0;
    int errors = 0;
    int cnt;

    pad_step_sequencer dut (
        .CLK       (clk),
        .RST       (rst_n),
        .Tick      (tick),
        .Run       (run),
        .PadValid  (pad_valid),
        .PadStep   (pad_step),
        .PadRow    (pad_row),
        .Clear     (clear),
        .Step      (step),
        .Column    (column),
        .StepStrobe(step_strobe),
        .Busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] s, input logic [2:0] r);
        pad_valid = 1'b1;
        pad_step  = s;
        pad_row   = r;
        cyc();
        pad_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_step"},   32'(step), 32'd0);
        check({tag, "_col"},    32'(column), 32'h00);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_strobe"}, 32'(step_strobe), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; run = 1'b0; pad_valid = 1'b0; clear = 1'b0;
        pad_step = '0; pad_row = '0;
        cyc(); cyc();
        check_reset_vals("reset");
        rst_n = 1'b1;
        cyc();
        check_reset_vals("post_reset");

        // Two pads in column 1, then one advance.
        run = 1'b1; cyc();
        press(3'd1, 3'd3);
        press(3'd1, 3'd5);
        tick = 1'b1; cyc(); tick = 1'b0;
        check("adv_step",   32'(step), 32'd1);
        check("adv_strobe", 32'(step_strobe), 32'd1);
        check("adv_col",    32'(column), 32'h28);
        cyc();
        check("adv_strobe_off", 32'(step_strobe), 32'd0);
        check("adv_col_hold",   32'(column), 32'h28);

        // Walk to step 7, then 8 ticks wrapping back to 7.
        tick = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        check("walk_step7", 32'(step), 32'd7);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (step_strobe) cnt++;
            if (i == 0) check("wrap_step0", 32'(step), 32'd0);
        end
        tick = 1'b0;
        cyc();
        check("wrap_strobes", 32'(cnt), 32'd8);
        check("wrap_step7",   32'(step), 32'd7);
        check("wrap_col7",    32'(column), 32'h00);
        check("wrap_strobe_off", 32'(step_strobe), 32'd0);

        // IDLE: toggles on the shown step, ticks ignored, step kept.
        run = 1'b0; cyc();
        check("idle_step_kept", 32'(step), 32'd7);
        press(3'd7, 3'd0);
        check("tog1_stale", 32'(column), 32'h00);
        cyc();
        check("tog1_col", 32'(column), 32'h01);
        press(3'd7, 3'd0);
        cyc();
        check("tog0_col", 32'(column), 32'h00);
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("idle_tick_step",   32'(step), 32'd7);
            check("idle_tick_strobe", 32'(step_strobe), 32'd0);
        end
        tick = 1'b0;

        // Simultaneous tick (1->2) and toggle of the new step.
        run = 1'b1; cyc();
        tick = 1'b1; cyc(); cyc(); tick = 1'b0;
        check("pre_sim_step", 32'(step), 32'd1);
        check("pre_sim_col",  32'(column), 32'h28);
        tick = 1'b1;
        press(3'd2, 3'd7);
        tick = 1'b0;
        check("sim_step",   32'(step), 32'd2);
        check("sim_strobe", 32'(step_strobe), 32'd1);
        check("sim_col_stale", 32'(column), 32'h00);
        cyc();
        check("sim_col_new", 32'(column), 32'h80);
        check("sim_strobe_off", 32'(step_strobe), 32'd0);

        // Clear with Run=1; same-cycle tick/pad and everything during the sweep dropped.
        clear = 1'b1; tick = 1'b1; pad_valid = 1'b1; pad_step = 3'd0; pad_row = 3'd1;
        cyc();
        clear = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) cnt++;
            tick      = (i < 8);
            pad_valid = (i < 8);
            clear     = (i == 4);
            cyc();
        end
        tick = 1'b0; pad_valid = 1'b0; clear = 1'b0;
        check("clr_busy_cycles", 32'(cnt), 32'd8);
        check("clr_step",   32'(step), 32'd0);
        check("clr_col",    32'(column), 32'h00);
        check("clr_strobe", 32'(step_strobe), 32'd0);
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("clr_walk_strobe", 32'(step_strobe), 32'd1);
            check("clr_walk_col",    32'(column), 32'h00);
        end
        tick = 1'b0;
        cyc();
        check("clr_walk_step", 32'(step), 32'd0);

        // Reset in the middle of a second sweep.
        press(3'd0, 3'd4);
        press(3'd7, 3'd6);
        cyc();
        check("preset_col0", 32'(column), 32'h10);
        clear = 1'b1; cyc(); clear = 1'b0;
        check("sweep2_busy", 32'(busy), 32'd1);
        cyc(); cyc(); cyc();
        rst_n = 1'b0; cyc();
        check_reset_vals("abort");
        rst_n = 1'b1; run = 1'b0; cyc();
        check_reset_vals("abort_idle");
        run = 1'b1; cyc();
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("abort_walk_col", 32'(column), 32'h00);
        end
        tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
